// File: rtl/multiplier_control_pkg.sv
// Shared types and helpers for the add-shift multiplier sequencer.
package mult_pkg;

  typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, HOLD} mult_state_t;

  localparam int MULT_N = 8;

  // True on the final add/shift pair, where the MSB weight is negative.
  function automatic logic is_last_step(input int unsigned step, input int unsigned n);
    return step == n - 1;
  endfunction

endpackage

// File: rtl/multiplier_control_if.sv
// Control bundle between the multiplier sequencer and its datapath/switches.
interface multiplier_control_if;
  // Run is a level request: held high starts one multiply, and Done stays
  // high until Run is released; it is not a per-cycle valid/ready handshake.
  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic Clr_XA;
  logic Ld_B;
  logic Add;
  logic Sub;
  logic Shift_En;
  logic Busy;
  logic Done;

  modport master (
    output Run, ClearA_LoadB, M,
    input  Clr_XA, Ld_B, Add, Sub, Shift_En, Busy, Done
  );

  modport slave (
    input  Run, ClearA_LoadB, M,
    output Clr_XA, Ld_B, Add, Sub, Shift_En, Busy, Done
  );
endinterface

// File: rtl/multiplier_control_step_counter.sv
// Add/shift step counter: 0..N-1, cleared at the start of each multiply.
module mult_step_counter
  import mult_pkg::*;
#(
  parameter int N = MULT_N,
  parameter int W = $clog2(N)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] step,
  output logic         last
);

  logic [W-1:0] step_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)    step_q <= '0;
    else if (clr) step_q <= '0;
    else if (inc) step_q <= step_q + W'(1);
  end

  assign step = step_q;
  assign last = is_last_step(32'(step_q), N);

endmodule

// File: rtl/multiplier_control.sv
// Sequencing FSM for the signed add-shift multiplier: N add/shift pairs,
// subtract on the last pair, then hold Done until Run is released.
module multiplier_control
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic                   Clk,
  input  logic                   Reset,
  multiplier_control_if.slave    bus,
  output mult_state_t            state_o,
  output logic [$clog2(N)-1:0]   step_o
);

  localparam int W = $clog2(N);

  mult_state_t  state_q, state_d;
  logic [W-1:0] step;
  logic         last;

  mult_step_counter #(.N(N), .W(W)) u_step (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (state_q == CLR),
    .inc   ((state_q == SHIFT) && !last),
    .step  (step),
    .last  (last)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Run is only sampled in IDLE and HOLD; mid-multiply changes are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.Run) state_d = CLR;
      CLR:     state_d = ADD;
      ADD:     state_d = SHIFT;
      SHIFT:   state_d = last ? HOLD : ADD;
      HOLD:    if (!bus.Run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic clr_xa, ld_b, add, sub, shift_en, busy, done;

  // Reset gates every strobe so the datapath sees nothing while it is held.
  always_comb begin
    clr_xa   = 1'b0;
    ld_b     = 1'b0;
    add      = 1'b0;
    sub      = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    if (!Reset) begin
      case (state_q)
        IDLE: begin
          clr_xa = bus.ClearA_LoadB;
          ld_b   = bus.ClearA_LoadB && !bus.Run;
        end
        CLR: begin
          clr_xa = 1'b1;
          busy   = 1'b1;
        end
        ADD: begin
          add  = bus.M && !last;
          sub  = bus.M && last;
          busy = 1'b1;
        end
        SHIFT: begin
          shift_en = 1'b1;
          busy     = 1'b1;
        end
        HOLD:    done = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.Clr_XA   = clr_xa;
  assign bus.Ld_B     = ld_b;
  assign bus.Add      = add;
  assign bus.Sub      = sub;
  assign bus.Shift_En = shift_en;
  assign bus.Busy     = busy;
  assign bus.Done     = done;

  assign state_o = state_q;
  assign step_o  = step;

endmodule

// File: tb/tb_multiplier_control.sv
// Directed bench for multiplier_control (N=8).
module tb_multiplier_control;
  import mult_pkg::*;

  localparam int N = 8;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  multiplier_control_if bus ();
  mult_state_t state;
  logic [2:0]  step;

  multiplier_control #(.N(N)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .bus     (bus),
    .state_o (state),
    .step_o  (step)
  );

  // {Clr_XA, Ld_B, Add, Sub, Shift_En, Busy, Done}
  wire [6:0] outs = {bus.Clr_XA, bus.Ld_B, bus.Add, bus.Sub, bus.Shift_En, bus.Busy, bus.Done};

  int n_cmp  = 0;
  int n_fail = 0;
  logic [6:0] obs [0:18];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Expected strobes in cycle c after the accept edge (c=0 is the IDLE cycle with Run high).
  function automatic logic [6:0] exp_outs(input logic [7:0] mseq, input logic clb, input int c);
    int   s;
    logic m;
    if (c == 0)  return {clb, 6'b000000};
    if (c == 1)  return 7'b1000010;
    if (c >= 18) return 7'b0000001;
    if (c % 2 == 1) return 7'b0000110;
    s = (c - 2) / 2;
    m = mseq[s];
    return {2'b00, m && (s != N - 1), m && (s == N - 1), 3'b010};
  endfunction

  // ---------------- driver ----------------
  // Runs one multiply from IDLE, recording outputs for cycles 0..18.
  task automatic run_seq(input logic [7:0] mseq, input logic clb, input int drop_cycle);
    bus.Run          = 1'b1;
    bus.ClearA_LoadB = clb;
    bus.M            = 1'b0;
    #1;
    obs[0] = outs;
    tick();
    for (int c = 1; c <= 18; c++) begin
      bus.Run = (c != drop_cycle);
      bus.M   = (c >= 2 && c <= 17) ? mseq[(c - 2) / 2] : 1'b0;
      #1;
      obs[c] = outs;
      if (c < 18) tick();
    end
    bus.Run = 1'b1;
  endtask

  task automatic release_run();
    bus.Run          = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    bus.M            = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (state !== IDLE || outs !== 7'b0) begin
      n_fail++;
      $display("FAIL release_idle state=%s outs=%b required IDLE/0000000", state.name(), outs);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.Run = 1'b0; bus.ClearA_LoadB = 1'b1; bus.M = 1'b1;
    Reset = 1'b1;
    tick(); tick();
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++; $display("FAIL reset_outs got=%b required=0000000", outs);
    end
    n_cmp++;
    if (state !== IDLE || step !== 3'd0) begin
      n_fail++; $display("FAIL reset_state got=%s/%0d required=IDLE/0", state.name(), step);
    end
    Reset = 1'b0;
    #1;
    n_cmp++;
    if (outs !== 7'b1100000) begin
      n_fail++; $display("FAIL idle_clear_load got=%b required=1100000", outs);
    end
    bus.ClearA_LoadB = 1'b0; bus.M = 1'b0;
    #1;
    n_cmp++;
    if (outs !== 7'b0) begin
      n_fail++; $display("FAIL idle_quiet got=%b required=0000000", outs);
    end
  endtask

  task automatic test_m_stream();
    logic [7:0] add_mask, sub_mask;
    int shifts;
    add_mask = '0; sub_mask = '0; shifts = 0;
    run_seq(8'b10001101, 1'b0, 0);
    for (int c = 0; c <= 18; c++) begin
      n_cmp++;
      if (obs[c] !== exp_outs(8'b10001101, 1'b0, c)) begin
        n_fail++;
        $display("FAIL mstream_cycle%0d got=%b required=%b", c, obs[c], exp_outs(8'b10001101, 1'b0, c));
      end
      if (c >= 2 && c <= 17 && c % 2 == 0) begin
        add_mask[(c - 2) / 2] = obs[c][4];
        sub_mask[(c - 2) / 2] = obs[c][3];
      end
      if (obs[c][2]) shifts++;
    end
    n_cmp++;
    if (add_mask !== 8'b00001101) begin
      n_fail++; $display("FAIL mstream_add_steps got=%b required=00001101", add_mask);
    end
    n_cmp++;
    if (sub_mask !== 8'b10000000) begin
      n_fail++; $display("FAIL mstream_sub_steps got=%b required=10000000", sub_mask);
    end
    n_cmp++;
    if (shifts != 8) begin
      n_fail++; $display("FAIL mstream_shifts got=%0d required=8", shifts);
    end
    n_cmp++;
    if (obs[17][0] !== 1'b0 || obs[18][0] !== 1'b1) begin
      n_fail++; $display("FAIL mstream_done_t18 got=%b%b required=01", obs[17][0], obs[18][0]);
    end
    release_run();
  endtask

  task automatic test_all_zero();
    int dead, shifts;
    dead = 0; shifts = 0;
    run_seq(8'h00, 1'b0, 0);
    for (int c = 0; c <= 18; c++) begin
      n_cmp++;
      if (obs[c] !== exp_outs(8'h00, 1'b0, c)) begin
        n_fail++;
        $display("FAIL zero_cycle%0d got=%b required=%b", c, obs[c], exp_outs(8'h00, 1'b0, c));
      end
      if (obs[c] == 7'b0000010) dead++;
      if (obs[c][2]) shifts++;
    end
    n_cmp++;
    if (dead != 8 || shifts != 8) begin
      n_fail++; $display("FAIL zero_counts dead=%0d shifts=%0d required=8/8", dead, shifts);
    end
    release_run();
  endtask

  // ClearA_LoadB held high with Run from IDLE through ADD, SHIFT and HOLD.
  task automatic test_clear_load_gating();
    run_seq(8'hFF, 1'b1, 0);
    for (int c = 0; c <= 18; c++) begin
      n_cmp++;
      if (obs[c] !== exp_outs(8'hFF, 1'b1, c)) begin
        n_fail++;
        $display("FAIL clb_cycle%0d got=%b required=%b", c, obs[c], exp_outs(8'hFF, 1'b1, c));
      end
    end
    tick();
    n_cmp++;
    if (outs !== 7'b0000001) begin
      n_fail++; $display("FAIL clb_hold got=%b required=0000001", outs);
    end
    release_run();
  endtask

  task automatic test_run_held();
    int shifts;
    shifts = 0;
    run_seq(8'h55, 1'b0, 0);
    n_cmp++;
    if (obs[18] !== 7'b0000001) begin
      n_fail++; $display("FAIL held_done got=%b required=0000001", obs[18]);
    end
    for (int i = 0; i < 22; i++) begin
      tick();
      n_cmp++;
      if (outs !== 7'b0000001 || state !== HOLD) begin
        n_fail++; $display("FAIL held_cycle%0d got=%b/%s required=0000001/HOLD", i, outs, state.name());
      end
    end
    release_run();
    run_seq(8'h0F, 1'b0, 0);
    for (int c = 0; c <= 18; c++) if (obs[c][2]) shifts++;
    n_cmp++;
    if (shifts != 8 || obs[18] !== 7'b0000001) begin
      n_fail++; $display("FAIL second_multiply shifts=%0d done=%b required=8/1", shifts, obs[18][0]);
    end
    release_run();
  endtask

  task automatic test_run_drop();
    run_seq(8'b10001101, 1'b0, 10);
    for (int c = 0; c <= 18; c++) begin
      n_cmp++;
      if (obs[c] !== exp_outs(8'b10001101, 1'b0, c)) begin
        n_fail++;
        $display("FAIL drop_cycle%0d got=%b required=%b", c, obs[c], exp_outs(8'b10001101, 1'b0, c));
      end
    end
    release_run();
  endtask

  task automatic test_reset_mid();
    bus.Run = 1'b1; bus.M = 1'b0; bus.ClearA_LoadB = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) tick();
    #1;
    n_cmp++;
    if (state !== SHIFT || step !== 3'd3 || outs !== 7'b0000110) begin
      n_fail++;
      $display("FAIL mid_pre got=%s/%0d/%b required=SHIFT/3/0000110", state.name(), step, outs);
    end
    bus.ClearA_LoadB = 1'b1;
    Reset = 1'b1;
    #1;
    n_cmp++;
    if (outs !== 7'b0 || state !== IDLE || step !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset got=%s/%0d/%b required=IDLE/0/0000000", state.name(), step, outs);
    end
    tick();
    Reset = 1'b0; bus.Run = 1'b0; bus.ClearA_LoadB = 1'b0;
    tick();
    run_seq(8'b10001101, 1'b0, 0);
    for (int c = 0; c <= 18; c++) begin
      n_cmp++;
      if (obs[c] !== exp_outs(8'b10001101, 1'b0, c)) begin
        n_fail++;
        $display("FAIL after_reset_cycle%0d got=%b required=%b", c, obs[c], exp_outs(8'b10001101, 1'b0, c));
      end
    end
    release_run();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_m_stream();
    test_all_zero();
    test_clear_load_gating();
    test_run_held();
    test_run_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
